// File: rtl/divider_top.sv
// Iterative radix-2 restoring divider: 2N-bit dividend / N-bit divisor -> N-bit quotient
// and remainder, one quotient bit per cycle, with start/busy/finish handshake.
module divider_top #(
  parameter int DATA_LENGTH = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     busy_o,
  output logic                     finish_o,
  input  logic [2*DATA_LENGTH-1:0] indata_a_i,
  input  logic [DATA_LENGTH-1:0]   indata_b_i,
  output logic [DATA_LENGTH-1:0]   quotient_o,
  output logic [DATA_LENGTH-1:0]   remainder_o,
  output logic                     div_zero_o,
  output logic                     overflow_o
);

  localparam int N  = DATA_LENGTH;
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_COMPUTE,
    S_FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   rem_q, q_q, divisor_q;
  logic [CW-1:0]  cnt_q;

  logic [N-1:0]   dvd_hi, dvd_lo;
  logic           div_zero, overflow;
  logic [N:0]     trial;
  logic           fits;
  logic [N-1:0]   rem_nx, q_nx;
  logic           last;

  always_comb begin
    dvd_hi   = indata_a_i[2*N-1:N];
    dvd_lo   = indata_a_i[N-1:0];
    div_zero = (indata_b_i == '0);
    overflow = (dvd_hi >= indata_b_i);
    // Compare is N+1 bits; when it fits, the true difference is below the divisor,
    // so the low N bits of the subtraction are exact.
    trial    = {rem_q, q_q[N-1]};
    fits     = (trial >= {1'b0, divisor_q});
    rem_nx   = fits ? (trial[N-1:0] - divisor_q) : trial[N-1:0];
    q_nx     = {q_q[N-2:0], fits};
    last     = (cnt_q == CW'(N-1));
  end

  // NOTE: next-state logic is combinational with a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_i) state_d = S_INIT;
      S_INIT:    state_d = (div_zero || overflow) ? S_FINISH : S_COMPUTE;
      S_COMPUTE: if (last) state_d = S_FINISH;
      S_FINISH:  state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign busy_o   = (state_q == S_INIT) || (state_q == S_COMPUTE);
  assign finish_o = (state_q == S_FINISH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Results are loaded on the edge entering finish so they are valid alongside finish_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q       <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      cnt_q       <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
      overflow_o  <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          divisor_q   <= indata_b_i;
          cnt_q       <= '0;
          rem_q       <= dvd_hi;
          q_q         <= dvd_lo;
          quotient_o  <= (div_zero || overflow) ? '1 : '0;
          remainder_o <= div_zero ? dvd_lo : '0;
          div_zero_o  <= div_zero;
          overflow_o  <= !div_zero && overflow;
        end
        S_COMPUTE: begin
          rem_q <= rem_nx;
          q_q   <= q_nx;
          cnt_q <= cnt_q + CW'(1);
          if (last) begin
            quotient_o  <= q_nx;
            remainder_o <= rem_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_top.sv
// Self-checking bench for divider_top: directed handshake/error/reset cases plus
// randomized operands compared against a plain-arithmetic reference.
module tb_divider_top;

  localparam int N = 32;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic           busy_o, finish_o;
  logic [2*N-1:0] indata_a_i;
  logic [N-1:0]   indata_b_i;
  logic [N-1:0]   quotient_o, remainder_o;
  logic           div_zero_o, overflow_o;

  int total  = 0;
  int passed = 0;

  divider_top #(.DATA_LENGTH(N)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .finish_o    (finish_o),
    .indata_a_i  (indata_a_i),
    .indata_b_i  (indata_b_i),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: plain 64-bit division with the error rules applied first.
  task automatic model(input logic [63:0] a, input logic [31:0] b,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic dz, output logic ov, output int lat);
    longint unsigned ua, ub;
    ua = a; ub = {32'd0, b};
    dz = 0; ov = 0;
    if (b == 0) begin
      dz = 1; q = '1; r = a[31:0]; lat = 2;
    end else if ((ua >> 32) >= ub) begin
      ov = 1; q = '1; r = 0; lat = 2;
    end else begin
      q = 32'(ua / ub); r = 32'(ua % ub); lat = N + 2;
    end
  endtask

  // Call in an idle cycle (cycle 0); returns in cycle 1 with start dropped.
  task automatic start_op(input logic [63:0] a, input logic [31:0] b);
    indata_a_i = a;
    indata_b_i = b;
    start_i    = 1'b1;
    tick();
    start_i    = 1'b0;
  endtask

  task automatic wait_finish(inout int cyc);
    while (!finish_o && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [63:0] a, input logic [31:0] b);
    logic [31:0] eq, er;
    logic        edz, eov;
    int          elat, cyc;
    longint unsigned recon;
    model(a, b, eq, er, edz, eov, elat);
    start_op(a, b);
    cyc = 1;
    wait_finish(cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(elat));
    check({tag, "_q"},   64'(quotient_o), 64'(eq));
    check({tag, "_r"},   64'(remainder_o), 64'(er));
    check({tag, "_dz"},  64'(div_zero_o), 64'(edz));
    check({tag, "_ov"},  64'(overflow_o), 64'(eov));
    if (!edz && !eov) begin
      recon = longint'(quotient_o) * longint'(b) + longint'(remainder_o);
      check({tag, "_rlt"},   64'(remainder_o < b), 64'd1);
      check({tag, "_recon"}, recon, a);
    end
    tick();
    check({tag, "_hold"}, {busy_o, finish_o, quotient_o}, {2'b00, eq});
  endtask

  initial begin
    int cyc;
    logic [31:0] ub, lo;
    logic        bad;

    rst_i = 1'b1; start_i = 1'b0; indata_a_i = '0; indata_b_i = '0;
    tick(); tick();
    check("rst_ctl", {busy_o, finish_o, div_zero_o, overflow_o}, 4'b0000);
    check("rst_data", {quotient_o, remainder_o}, 64'd0);
    rst_i = 1'b0;
    tick();

    // Basic: per-cycle busy/finish timeline for 100/7.
    start_op(64'd100, 32'd7);
    for (int c = 1; c <= 35; c++) begin
      check($sformatf("basic_busy_c%0d", c), 64'(busy_o), 64'(c <= N + 1));
      check($sformatf("basic_fin_c%0d", c), 64'(finish_o), 64'(c == N + 2));
      if (c == N + 2) begin
        check("basic_q", 64'(quotient_o), 64'd14);
        check("basic_r", 64'(remainder_o), 64'd2);
      end
      tick();
    end

    do_op("inverse", 64'hFFFF_FFFE_0000_0001, 32'hFFFF_FFFF);
    do_op("divzero", 64'h5, 32'h0);
    do_op("ovf", 64'h1_0000_0000, 32'h1);
    do_op("maxok", 64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF);

    // Handshake: start held high through a run; operands change after init.
    indata_a_i = 64'd1000; indata_b_i = 32'd3; start_i = 1'b1;
    tick();
    tick(); cyc = 2;
    indata_a_i = 64'h0000_0012_3456_789A; indata_b_i = 32'h0000_1235;
    wait_finish(cyc);
    check("hs1_lat", 64'(cyc), 64'(N + 2));
    check("hs1_q", 64'(quotient_o), 64'd333);
    check("hs1_r", 64'(remainder_o), 64'd1);
    tick(); cyc++;
    check("hs_idle", {busy_o, finish_o}, 2'b00);
    tick(); cyc++;
    check("hs_init", 64'(busy_o), 64'd1);
    start_i = 1'b0;
    wait_finish(cyc);
    check("hs2_lat", 64'(cyc), 64'(2 * N + 5));
    check("hs2_q", 64'(quotient_o), 64'(64'h0000_0012_3456_789A / 64'h1235));
    check("hs2_r", 64'(remainder_o), 64'(64'h0000_0012_3456_789A % 64'h1235));
    tick();

    // Reset during compute cycle 10.
    start_op(64'd100, 32'd7);
    for (int c = 1; c < 10; c++) tick();
    rst_i = 1'b1;
    tick();
    check("midrst_ctl", {busy_o, finish_o, div_zero_o, overflow_o}, 4'b0000);
    check("midrst_data", {quotient_o, remainder_o}, 64'd0);
    rst_i = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy_o || finish_o) bad = 1'b1;
      tick();
    end
    check("midrst_quiet", 64'(bad), 64'd0);
    do_op("after_rst", 64'd100, 32'd7);

    // Random operands, mostly valid with some error cases mixed in.
    for (int i = 0; i < 300; i++) begin
      int kind;
      kind = $urandom_range(0, 15);
      lo   = $urandom;
      if (kind == 0) begin
        ub = 0;
        indata_a_i = {32'($urandom), lo};
      end else if (kind == 1) begin
        ub = $urandom_range(1, 1000);
        indata_a_i = {ub + 32'($urandom_range(0, 1000)), lo};
      end else begin
        ub = (kind < 5) ? 32'($urandom_range(1, 255)) : 32'($urandom);
        if (ub == 0) ub = 1;
        indata_a_i = {32'($urandom) % ub, lo};
      end
      do_op("rand", indata_a_i, ub);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
